uart_wb_poller: RTL and testbench
=================================

// Module: uart_wb_poller
// PURPOSE
//  Wishbone master that sequences the UART controller by status polling, so cores/DMA need not spin on it.
//  Buffers outgoing bytes in a TX FIFO and writes them to the UART data register only when the status register reports TX ready.
//  Moves received bytes from the UART into a one-byte holding register with a valid/ready output.
//  Sits between producer/consumer logic and the UART controller's Wishbone slave port.
// PARAMETERS
//  UART_BASE   32'h1000_0000  byte address of the UART controller (data at +0x00, status at +0x05)
//  TX_DEPTH    16             TX FIFO entries; power of two, >=2
//  POLL_GAP    8              idle cycles between successive status polls; 0 = back-to-back
//  WB_TIMEOUT  255            cycles waited for wb_ack_i before aborting a transaction
// PORTS
//  clk_i       in   1   clock
//  rst_ni      in   1   synchronous reset, active low
//  tx_data_i   in   8   byte to transmit
//  tx_valid_i  in   1   tx_data_i valid
//  tx_ready_o  out  1   FIFO not full; byte accepted when valid&ready
//  rx_data_o   out  8   received byte
//  rx_valid_o  out  1   rx_data_o holds an unconsumed byte
//  rx_ready_i  in   1   consumer takes byte when valid&ready
//  tx_empty_o  out  1   TX FIFO empty and no write in flight
//  err_o       out  1   one-cycle pulse on bus timeout
//  wb_adr_o    out  32  Wishbone address
//  wb_dat_o    out  32  write data
//  wb_dat_i    in   32  read data
//  wb_we_o     out  1   write enable
//  wb_sel_o    out  4   byte select
//  wb_stb_o    out  1   strobe
//  wb_cyc_o    out  1   cycle
//  wb_ack_i    in   1   acknowledge
// BEHAVIOUR
//  One clock (clk_i); reset is synchronous and active-low (rst_ni); all outputs registered.
//  Reset values: wb_stb_o=wb_cyc_o=wb_we_o=0, wb_adr_o=0, wb_dat_o=0, wb_sel_o=0, rx_valid_o=0, rx_data_o=0,
//   err_o=0, tx_ready_o=1, tx_empty_o=1; FIFO pointers cleared; FSM=IDLE; gap counter=0.
//  Reset mid-transaction: stb/cyc drop at the reset edge; FIFO contents and held RX byte discarded.
//  FSM states: IDLE, POLL, TX_WR, RX_RD.
//   IDLE: when gap counter==0 and work pending (FIFO non-empty, or RX path enabled and rx_valid_o==0) -> POLL.
//   POLL: read adr=UART_BASE+5, sel=4'b0010, we=0; on ack sample status=wb_dat_i[15:8].
//     status[0]=1 and rx_valid_o==0 (RX enabled) -> RX_RD (RX has priority over TX);
//     else status[5]=1 and FIFO non-empty -> TX_WR; else -> IDLE, gap counter loads POLL_GAP.
//   TX_WR: write adr=UART_BASE, sel=4'b0001, we=1, dat[7:0]=FIFO head, dat[31:8]=0; on ack pop FIFO -> IDLE (gap=0).
//   RX_RD: read adr=UART_BASE, sel=4'b0001; on ack rx_data_o<=wb_dat_i[7:0], rx_valid_o<=1 -> IDLE (gap=0).
//  Bus handshake: stb/cyc/adr/we/sel/dat asserted together on state entry, held stable until ack;
//   the edge that samples wb_ack_i=1 deasserts stb/cyc (min 2 cycles per transfer, never a second ack).
//  Timeout: WB_TIMEOUT cycles without ack -> drop stb/cyc, err_o pulses 1 cycle, FSM -> IDLE, FIFO not popped,
//   RX byte not captured; transaction retried after POLL_GAP.
//  TX FIFO: push on tx_valid_i&tx_ready_o; pop only on TX_WR ack; push and pop same cycle legal (count unchanged).
//   Full: tx_ready_o=0, occupancy==TX_DEPTH; pointers wrap modulo TX_DEPTH; count is log2(TX_DEPTH)+1 bits.
//  RX holding: cleared on rx_valid_o&rx_ready_i; a new UART byte is never read while rx_valid_o=1 (no overrun).
//  tx_empty_o = FIFO empty and state!=TX_WR.
// CONFIGURATION
//  UART_POLL_RX_EN defined: RX path as above.
//  Undefined: RX_RD unreachable, status[0] ignored, rx_valid_o=0, rx_data_o=0, rx_ready_i unused;
//   polls occur only when the TX FIFO is non-empty.
// TESTING
//  Push 0x41,0x42,0x43; model status=0x20 -> three writes to UART_BASE, sel=0001, dat 0x41,0x42,0x43 in order; tx_empty_o=1 after.
//  Status=0x00 for 50 cycles then 0x20, one byte queued -> no data write until 0x20 seen; polls spaced POLL_GAP+2 cycles.
//  Push 17 bytes back-to-back with TX_DEPTH=16, slave stalled -> tx_ready_o=0 after 16th; 17th held until first pop.
//  RX_EN: status=0x21, data 0x5A, rx_ready_i=0 -> rx_valid_o=1, rx_data_o=0x5A; no further data read until rx_ready_i=1.
//  Slave never acks -> stb/cyc drop after WB_TIMEOUT cycles, err_o single pulse, FIFO count unchanged, retry follows.
//  rst_ni low during TX_WR with stb high -> stb/cyc=0 next edge, tx_empty_o=1, rx_valid_o=0.

Source files
------------

// File: rtl/uart_wb_poller.sv
// Wishbone master that polls a UART status register, drains a TX FIFO into the data register
// and (with UART_POLL_RX_EN defined) moves received bytes into a one-byte holding register.
module uart_wb_poller #(
  parameter logic [31:0] UART_BASE  = 32'h1000_0000,
  parameter int          TX_DEPTH   = 16,
  parameter int          POLL_GAP   = 8,
  parameter int          WB_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  tx_data_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic        tx_empty_o,
  output logic        err_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i
);

  localparam int AW = $clog2(TX_DEPTH);
  localparam int GW = $clog2(POLL_GAP + 2);
  localparam int TW = $clog2(WB_TIMEOUT + 1);
`ifdef UART_POLL_RX_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, POLL, TX_WR, RX_RD} state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [TW-1:0]   to_q, to_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     cnt_q, cnt_d;
  logic [7:0]      mem_q [TX_DEPTH];
  logic            stb_q, stb_d, we_q, we_d;
  logic [31:0]     adr_q, adr_d, dat_q, dat_d;
  logic [3:0]      sel_q, sel_d;
  logic            rx_valid_q, rx_valid_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            err_q, err_d;
  logic            tx_ready_q, tx_ready_d, tx_empty_q, tx_empty_d;
  logic            push, pop, fifo_ne;
  logic [7:0]      status;

  assign push    = tx_valid_i & tx_ready_q;
  assign fifo_ne = (cnt_q != '0);
  assign status  = wb_dat_i[15:8];

  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    to_d       = to_q;
    stb_d      = stb_q;
    we_d       = we_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    sel_d      = sel_q;
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    err_d      = 1'b0;
    pop        = 1'b0;
    if (RX_EN && rx_valid_q && rx_ready_i) rx_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (gap_q != '0) begin
          gap_d = gap_q - GW'(1);
        end else if (fifo_ne || (RX_EN && !rx_valid_q)) begin
          state_d = POLL;
          stb_d   = 1'b1;
          to_d    = '0;
          adr_d   = UART_BASE + 32'd5;
          sel_d   = 4'b0010;
          we_d    = 1'b0;
          dat_d   = '0;
        end
      end
      default: begin
        if (!stb_q) begin
          // Data phases start one cycle after the status ack so stb is seen low between transfers.
          stb_d = 1'b1;
          to_d  = '0;
          adr_d = UART_BASE;
          sel_d = 4'b0001;
          we_d  = (state_q == TX_WR);
          dat_d = (state_q == TX_WR) ? {24'h0, mem_q[rd_ptr_q]} : 32'h0;
        end else if (wb_ack_i) begin
          stb_d   = 1'b0;
          adr_d   = '0;
          sel_d   = '0;
          we_d    = 1'b0;
          dat_d   = '0;
          state_d = IDLE;
          gap_d   = '0;
          case (state_q)
            POLL: begin
              if (RX_EN && status[0] && !rx_valid_q) state_d = RX_RD;
              else if (status[5] && fifo_ne)         state_d = TX_WR;
              else                                   gap_d   = GW'(POLL_GAP);
            end
            TX_WR: pop = 1'b1;
            default: begin
              rx_data_d  = wb_dat_i[7:0];
              rx_valid_d = 1'b1;
            end
          endcase
        end else if (to_q == TW'(WB_TIMEOUT - 1)) begin
          stb_d   = 1'b0;
          adr_d   = '0;
          sel_d   = '0;
          we_d    = 1'b0;
          dat_d   = '0;
          err_d   = 1'b1;
          state_d = IDLE;
          gap_d   = GW'(POLL_GAP);
        end else begin
          to_d = to_q + TW'(1);
        end
      end
    endcase
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    tx_ready_d = (cnt_d != (AW+1)'(TX_DEPTH));
    tx_empty_d = (cnt_d == '0) && (state_d != TX_WR);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      gap_q      <= '0;
      to_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      err_q      <= 1'b0;
      tx_ready_q <= 1'b1;
      tx_empty_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      to_q       <= to_d;
      cnt_q      <= cnt_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      sel_q      <= sel_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      err_q      <= err_d;
      tx_ready_q <= tx_ready_d;
      tx_empty_q <= tx_empty_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= tx_data_i;
  end

  logic unused_in;
  assign unused_in = ^{wb_dat_i, rx_ready_i};

  assign tx_ready_o = tx_ready_q;
  assign tx_empty_o = tx_empty_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign err_o      = err_q;
  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = dat_q;
  assign wb_we_o    = we_q;
  assign wb_sel_o   = sel_q;
  assign wb_stb_o   = stb_q;
  assign wb_cyc_o   = stb_q;

endmodule

// File: tb/tb_uart_wb_poller.sv
// Directed + random bench for uart_wb_poller: a behavioural UART slave answers on the bus and a
// queue-based model predicts the bytes that must reach the data register, in push order.
module tb_uart_wb_poller;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int DEPTH = 16, GAP = 8, TMO = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, tx_valid, rx_ready, wb_ack;
  logic [7:0]  tx_data;
  logic [31:0] wb_dat_i;
  logic        tx_ready_o, rx_valid_o, tx_empty_o, err_o, wb_we_o, wb_stb_o, wb_cyc_o;
  logic [7:0]  rx_data_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;

  uart_wb_poller #(.UART_BASE(BASE), .TX_DEPTH(DEPTH), .POLL_GAP(GAP), .WB_TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready), .tx_empty_o(tx_empty_o),
    .err_o(err_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack));

  int n_assert = 0, n_fail = 0;
  int cyc_cnt = 0, rx_reads = 0, bad_cnt = 0, rxv_cnt = 0;
  bit stall = 0, stall_wr = 0, rand_stat = 0;
  logic [7:0] status = 8'h00, rx_byte = 8'h00;
  logic [7:0] wr_q[$], exp_q[$];
  int poll_t[$];

  always @(posedge clk) cyc_cnt++;
  always @(negedge clk) if (rx_valid_o) rxv_cnt++;

  // UART slave: acks in the first cycle stb is seen, unless stalled.
  always @(posedge clk) begin
    #2;
    wb_ack   = 1'b0;
    wb_dat_i = 32'h0;
    if (wb_stb_o !== wb_cyc_o) bad_cnt++;
    if (wb_cyc_o && wb_stb_o && !stall && !(stall_wr && wb_we_o)) begin
      wb_ack = 1'b1;
      if (wb_we_o) begin
        if (wb_adr_o != BASE || wb_sel_o != 4'b0001 || wb_dat_o[31:8] != 24'h0) bad_cnt++;
        wr_q.push_back(wb_dat_o[7:0]);
      end else if (wb_adr_o == BASE + 32'd5 && wb_sel_o == 4'b0010) begin
        if (rand_stat) status = ($urandom_range(0, 9) < 6) ? 8'h20 : 8'h00;
        wb_dat_i = {16'h0, status, 8'h00};
        poll_t.push_back(cyc_cnt);
      end else if (wb_adr_o == BASE && wb_sel_o == 4'b0001) begin
        wb_dat_i = {24'h0, rx_byte};
        rx_reads++;
      end else bad_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge one cycle after acceptance.
  task automatic push(input logic [7:0] b);
    int g = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready_o && g < 2000) begin @(negedge clk); g++; end
    chk("push_accept", {31'h0, tx_ready_o}, 32'd1);
    exp_q.push_back(b);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int lim);
    int g = 0;
    while (!(tx_empty_o && wr_q.size() == exp_q.size()) && g < lim) begin @(negedge clk); g++; end
    chk({tag, "_done"}, {31'h0, (tx_empty_o && wr_q.size() == exp_q.size())}, 32'd1);
    chk({tag, "_cnt"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) chk({tag, "_byte"}, {24'h0, wr_q[i]}, {24'h0, exp_q[i]});
    wr_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int g, n, base_reads;
    rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h0; rx_ready = 1'b0; wb_ack = 1'b0; wb_dat_i = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_stb", {31'h0, wb_stb_o}, 32'd0);
    chk("rst_cyc", {31'h0, wb_cyc_o}, 32'd0);
    chk("rst_we", {31'h0, wb_we_o}, 32'd0);
    chk("rst_adr", wb_adr_o, 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_sel", {28'h0, wb_sel_o}, 32'd0);
    chk("rst_rxv", {31'h0, rx_valid_o}, 32'd0);
    chk("rst_rxd", {24'h0, rx_data_o}, 32'd0);
    chk("rst_err", {31'h0, err_o}, 32'd0);
    chk("rst_rdy", {31'h0, tx_ready_o}, 32'd1);
    chk("rst_empty", {31'h0, tx_empty_o}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Three bytes with TX always ready
    status = 8'h20;
    push(8'h41); push(8'h42); push(8'h43);
    drain("t1", 500);
    chk("t1_empty", {31'h0, tx_empty_o}, 32'd1);

    // Status not ready: no write, polls spaced POLL_GAP+2
    status = 8'h00;
    poll_t.delete();
    push(8'h55);
    repeat (50) @(negedge clk);
    chk("t2_nowrite", wr_q.size(), 0);
    chk("t2_npolls", {31'h0, poll_t.size() >= 3}, 32'd1);
    for (int i = 1; i < poll_t.size(); i++) chk("t2_spacing", poll_t[i] - poll_t[i-1], GAP + 2);
    status = 8'h20;
    drain("t2", 500);

    // FIFO full with stalled slave
    stall = 1;
    for (int i = 0; i < DEPTH; i++) push(8'h80 + 8'(i));
    chk("t3_full", {31'h0, tx_ready_o}, 32'd0);
    tx_data = 8'h90; tx_valid = 1'b1;
    repeat (10) @(negedge clk);
    chk("t3_held", {31'h0, tx_ready_o}, 32'd0);
    chk("t3_nowrite", wr_q.size(), 0);
    stall = 0;
    g = 0;
    while (!tx_ready_o && g < 200) begin @(negedge clk); g++; end
    chk("t3_ready", {31'h0, tx_ready_o}, 32'd1);
    chk("t3_onepop", wr_q.size(), 1);
    exp_q.push_back(8'h90);
    @(negedge clk);
    tx_valid = 1'b0;
    drain("t3", 1000);

    // Slave never acks: timeout, error pulse, byte kept and retried
    stall = 1;
    push(8'h66);
    g = 0;
    while (wb_stb_o && g < 400) begin @(negedge clk); g++; end
    g = 0;
    while (!wb_stb_o && g < 100) begin @(negedge clk); g++; end
    chk("t4_started", {31'h0, wb_stb_o}, 32'd1);
    n = 0;
    while (wb_stb_o && n < 400) begin @(negedge clk); n++; end
    chk("t4_tmo_len", n, TMO);
    chk("t4_cyc_drop", {31'h0, wb_cyc_o}, 32'd0);
    chk("t4_err", {31'h0, err_o}, 32'd1);
    chk("t4_kept", {31'h0, tx_empty_o}, 32'd0);
    @(negedge clk);
    chk("t4_err_pulse", {31'h0, err_o}, 32'd0);
    chk("t4_nowrite", wr_q.size(), 0);
    stall = 0;
    drain("t4", 1000);

    // Random bytes, random push spacing, random status answers
    rand_stat = 1;
    for (int i = 0; i < 30; i++) begin
      push(8'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain("t5", 20000);
    rand_stat = 0;
    status = 8'h20;

`ifdef UART_POLL_RX_EN
    // RX byte held until consumed; no further reads meanwhile
    base_reads = rx_reads;
    status = 8'h21; rx_byte = 8'h5A;
    g = 0;
    while (!rx_valid_o && g < 200) begin @(negedge clk); g++; end
    chk("rx_valid", {31'h0, rx_valid_o}, 32'd1);
    chk("rx_data", {24'h0, rx_data_o}, 32'h5A);
    repeat (40) @(negedge clk);
    chk("rx_noreread", rx_reads - base_reads, 1);
    chk("rx_still", {31'h0, rx_valid_o}, 32'd1);
    rx_byte = 8'hA5;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    chk("rx_consumed", {31'h0, rx_valid_o}, 32'd0);
    g = 0;
    while (!rx_valid_o && g < 200) begin @(negedge clk); g++; end
    chk("rx_data2", {24'h0, rx_data_o}, 32'hA5);
    chk("rx_reads2", rx_reads - base_reads, 2);
    status = 8'h20;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
`else
    base_reads = 0;
    chk("rx_off_valid", rxv_cnt, base_reads);
    chk("rx_off_reads", rx_reads, 0);
    chk("rx_off_data", {24'h0, rx_data_o}, 32'd0);
`endif

    // Reset during a stalled data write
    stall_wr = 1;
    push(8'h77);
    g = 0;
    while (!(wb_stb_o && wb_we_o) && g < 200) begin @(negedge clk); g++; end
    chk("t6_in_wr", {31'h0, (wb_stb_o && wb_we_o)}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_stb", {31'h0, wb_stb_o}, 32'd0);
    chk("t6_cyc", {31'h0, wb_cyc_o}, 32'd0);
    chk("t6_empty", {31'h0, tx_empty_o}, 32'd1);
    chk("t6_rxv", {31'h0, rx_valid_o}, 32'd0);
    chk("t6_rdy", {31'h0, tx_ready_o}, 32'd1);
    rst_n = 1'b1;
    stall_wr = 0;
    exp_q.delete();
    repeat (60) @(negedge clk);
    chk("t6_discard", wr_q.size(), 0);
    chk("bus_protocol", bad_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
